fib_chk: RTL and testbench
==========================

FIB_CHK -- requirements
Module: fib_chk

Interface
REQ-001 Parameter WIDTH, default 4, term width in bits; all arithmetic is modulo 2^WIDTH.
REQ-002 Parameter CNT_W, default 8, width of term_cnt.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 Port en  input  1  checker enable.
REQ-006 Port clr  input  1  synchronous clear of err_sticky.
REQ-007 Port in_valid  input  1  producer has a term on in_data.
REQ-008 Port in_data  input  WIDTH  term under check.
REQ-009 Port in_ready  output  1  checker accepts a term this cycle.
REQ-010 Port locked  output  1  at least 3 consecutive terms checked correct.
REQ-011 Port err  output  1  one-cycle pulse on mismatch.
REQ-012 Port err_sticky  output  1  mismatch seen since last clr or reset.
REQ-013 Port err_exp  output  WIDTH  expected value at last mismatch.
REQ-014 Port term_cnt  output  CNT_W  consecutive correct checked terms, saturating.

Function
REQ-015 Transfer occurs when in_valid and in_ready are both high on a rising edge; no other cycle changes a, b or the counters.
REQ-016 in_ready SHALL be high exactly when en is high and state is not IDLE, with no combinational path from in_valid.
REQ-017 States: IDLE, SEED0, SEED1, CHECK.
REQ-018 IDLE: en high moves to SEED0 the next cycle; en low in any state forces IDLE the next cycle, clears locked, and keeps term_cnt, err_sticky and err_exp.
REQ-019 SEED0: a transfer stores in_data as a and moves to SEED1.
REQ-020 SEED1: a transfer stores in_data as b and moves to CHECK.
REQ-021 CHECK, transfer with in_data == (a+b) mod 2^WIDTH: a<=b, b<=in_data, term_cnt increments and saturates at 2^CNT_W-1.
REQ-022 locked SHALL rise the cycle after the transfer that brings term_cnt to 3 or more.
REQ-023 CHECK, transfer with a mismatch: err pulses for one cycle, err_sticky<=1, err_exp<=(a+b) mod 2^WIDTH, term_cnt<=0, locked<=0, a<=in_data, and the state moves to SEED1 (auto-resync).
REQ-024 All outputs except in_ready are registered and update one cycle after the transfer.
REQ-025 A mismatch and clr in the same cycle leave err_sticky=1 (set wins).
REQ-026 A mismatch while term_cnt is saturated still clears term_cnt.

Reset
REQ-027 rst low immediately forces state IDLE and sets a, b, term_cnt, err_exp, locked, err and err_sticky to 0; in_ready is 0.
REQ-028 Reset asserted mid-sequence discards all seeds; after release, checking restarts from SEED0 once en is high.

Configuration
REQ-029 Macro FIB_CHK_STRICT_SEED_EN defined: the SEED0 term must be 0 and the SEED1 term must be 1; any other seed is a mismatch handled per REQ-023, with err_exp equal to the required seed value.
REQ-030 Macro FIB_CHK_STRICT_SEED_EN undefined: any two seeds are accepted without error.

Structure
REQ-031 Package fib_pkg holds the state enum typedef, LOCK_THRESH=3, and the default WIDTH and CNT_W.
REQ-032 One combinational sub-module, fib_next, computes (a+b) mod 2^WIDTH.
REQ-033 fib_next is shared with the Fibonacci generator.

Verification (WIDTH=4, in_valid held high, en high)
REQ-034 Stream 0,1,1,2,3,5,8,13,5,2: err never pulses; locked rises the cycle after term 3 is accepted; final term_cnt=8.
REQ-035 Stream 0,1,1,2,4: err pulses once with err_exp=3, term_cnt=0, locked=0; then 6,10 gives no error and term_cnt=1.
REQ-036 Drop en for 2 cycles after 0,1,1: in_ready=0 and locked=0; after re-enable, 5,8,13 gives no error because the seeds are relearned.
REQ-037 Mismatch in the same cycle as clr: err_sticky=1; clr alone on the next cycle: err_sticky=0.
REQ-038 rst low mid-stream at an arbitrary phase: all outputs read 0 immediately, and the next accepted term is treated as SEED0.
REQ-039 FIB_CHK_STRICT_SEED_EN defined, stream 2,3: err pulses with err_exp=0; the next term 1 is then accepted as the SEED1 term without error.

Source files
------------

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
//
// Purpose: shared definitions for the Fibonacci sequence checker and any
// Fibonacci generator built on the same adder.
//   - fib_state_e   : checker state encoding (IDLE, SEED0, SEED1, CHECK)
//   - DEFAULT_WIDTH : default term width in bits
//   - DEFAULT_CNT_W : default width of the consecutive-correct counter
//   - LOCK_THRESH   : number of consecutive correct terms needed for lock
//   - SEED0_VALUE / SEED1_VALUE : canonical seeds, enforced only when the
//     checker is built with FIB_CHK_STRICT_SEED_EN defined
//
// Ports: none (package only).
// -----------------------------------------------------------------------------
package fib_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 8;
    localparam int LOCK_THRESH   = 3;

    // The canonical Fibonacci sequence starts 0, 1.
    localparam int SEED0_VALUE = 0;
    localparam int SEED1_VALUE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED0 = 2'd1,
        SEED1 = 2'd2,
        CHECK = 2'd3
    } fib_state_e;

endpackage : fib_pkg

// File: rtl/fib_next.sv
// -----------------------------------------------------------------------------
// fib_next
//
// Purpose: purely combinational next-term computation for a Fibonacci
// sequence, sum_o = (a_i + b_i) mod 2^WIDTH. The same block serves the
// checker and the Fibonacci generator, so both agree on the wrap behaviour.
//
// Parameters:
//   WIDTH : term width in bits
//
// Ports:
//   a_i   [WIDTH-1:0] in   older of the two previous terms
//   b_i   [WIDTH-1:0] in   newer of the two previous terms
//   sum_o [WIDTH-1:0] out  next term, wrapped modulo 2^WIDTH
// -----------------------------------------------------------------------------
module fib_next
    import fib_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    // The carry out of the top bit is simply dropped, which is exactly the
    // modulo 2^WIDTH behaviour the sequence arithmetic wants.
    assign sum_o = a_i + b_i;

endmodule : fib_next

// File: rtl/fib_chk.sv
// -----------------------------------------------------------------------------
// fib_chk
//
// Purpose: checks that a valid/ready stream of terms follows the Fibonacci
// recurrence modulo 2^WIDTH. The first two accepted terms are learnt as
// seeds; every following term must equal the sum of the previous two. A
// wrong term raises a one-cycle err pulse, records the expected value and
// resynchronises by treating the wrong term as the new first seed.
//
// Configuration macro: FIB_CHK_STRICT_SEED_EN
//   defined   : the seeds must be exactly 0 then 1; any other seed counts
//               as a mismatch with err_exp holding the required seed
//   undefined : any two seeds are accepted
//
// Parameters:
//   WIDTH : term width in bits
//   CNT_W : width of term_cnt
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   en         in   1      checker enable; low returns the checker to IDLE
//   clr        in   1      synchronous clear of err_sticky
//   in_valid   in   1      producer has a term on in_data
//   in_data    in   WIDTH  term under check
//   in_ready   out  1      checker accepts a term this cycle
//   locked     out  1      at least LOCK_THRESH consecutive correct terms
//   err        out  1      one-cycle pulse on a mismatch
//   err_sticky out  1      mismatch seen since last clr or reset
//   err_exp    out  WIDTH  expected value at the last mismatch
//   term_cnt   out  CNT_W  consecutive correct checked terms, saturating
// -----------------------------------------------------------------------------
module fib_chk
    import fib_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [WIDTH-1:0] err_exp,
    output logic [CNT_W-1:0] term_cnt
);

    fib_state_e       state_q;
    fib_state_e       state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] errExp_q;
    logic [WIDTH-1:0] errExp_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             locked_q;
    logic             locked_d;
    logic             err_q;
    logic             err_d;
    logic             errSticky_q;
    logic             errSticky_d;

    logic             readyInt;
    logic             xfer;
    logic [WIDTH-1:0] sum;
    logic             seedBad;
    logic [WIDTH-1:0] seedExp;
    logic             mismatch;
    logic [WIDTH-1:0] expVal;
    logic [CNT_W-1:0] cntInc;

    // Shared adder producing the term the stream should deliver next.
    fib_next #(
        .WIDTH (WIDTH)
    ) u_fib_next (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (sum)
    );

    // A transfer is the only event that moves seeds, counters or error
    // state; in_ready depends on registered state and en only, so there is
    // no combinational path from in_valid back to in_ready.
    assign xfer = in_valid && readyInt;

    // Seed policy. In the default build seeds are learnt blindly; in the
    // strict build each seed must match the canonical value and the
    // required seed is what gets reported on a mismatch.
    always_comb begin
        seedBad = 1'b0;
        seedExp = '0;
`ifdef FIB_CHK_STRICT_SEED_EN
        if (state_q == SEED0) begin
            seedExp = WIDTH'(SEED0_VALUE);
            seedBad = (in_data != WIDTH'(SEED0_VALUE));
        end else if (state_q == SEED1) begin
            seedExp = WIDTH'(SEED1_VALUE);
            seedBad = (in_data != WIDTH'(SEED1_VALUE));
        end
`endif
    end

    // Mismatch detection and the value that should have arrived. In CHECK
    // the reference is the recurrence; in the seed states it can only be a
    // strict-mode seed violation.
    always_comb begin
        mismatch = 1'b0;
        expVal   = seedExp;
        if (state_q == CHECK) begin
            expVal = sum;
        end
        if (xfer) begin
            mismatch = ((state_q == CHECK) && (in_data != sum)) || seedBad;
        end
    end

    // Saturating increment: once the counter is all ones it stays there
    // until a mismatch or reset clears it.
    assign cntInc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. Dropping en always parks the checker in IDLE,
    // which forces the seeds to be relearnt from SEED0 on re-enable. A
    // mismatch resynchronises by waiting only for the second seed, since
    // the offending term has already been taken as the first one.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SEED0;
                end
                SEED0: begin
                    if (xfer) begin
                        state_d = SEED1;
                    end
                end
                SEED1: begin
                    if (xfer) begin
                        state_d = mismatch ? SEED1 : CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        state_d = SEED1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM output logic: the checker is ready whenever it is enabled and has
    // left IDLE.
    always_comb begin
        readyInt = en && (state_q != IDLE);
    end

    // Datapath next-state. clr is applied first so that a mismatch in the
    // same cycle overrides it and the sticky flag stays set. The counter and
    // err_exp survive an en drop; only locked is cleared.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        errSticky_d = errSticky_q;
        errExp_d    = errExp_q;

        if (clr) begin
            errSticky_d = 1'b0;
        end

        if (mismatch) begin
            err_d       = 1'b1;
            errSticky_d = 1'b1;
            errExp_d    = expVal;
            cnt_d       = '0;
            locked_d    = 1'b0;
            a_d         = in_data;
        end else if (xfer) begin
            case (state_q)
                SEED0: begin
                    a_d = in_data;
                end
                SEED1: begin
                    b_d = in_data;
                end
                CHECK: begin
                    a_d   = b_q;
                    b_d   = in_data;
                    cnt_d = cntInc;
                    if (cntInc >= CNT_W'(LOCK_THRESH)) begin
                        locked_d = 1'b1;
                    end
                end
                default: begin
                    a_d = a_q;
                end
            endcase
        end

        if (!en) begin
            locked_d = 1'b0;
        end
    end

    // Datapath and status registers; all clear asynchronously so every
    // registered output reads zero as soon as reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            errSticky_q <= 1'b0;
            errExp_q    <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            errSticky_q <= errSticky_d;
            errExp_q    <= errExp_d;
        end
    end

    assign in_ready   = readyInt;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_sticky = errSticky_q;
    assign err_exp    = errExp_q;
    assign term_cnt   = cnt_q;

endmodule : fib_chk

// File: tb/tb_fib_chk.sv
// -----------------------------------------------------------------------------
// tb_fib_chk
//
// Self-checking bench for fib_chk (WIDTH=4, CNT_W=8). A reference model
// keeps the accepted terms in a queue and predicts every output from the
// Fibonacci rule directly. Honours FIB_CHK_STRICT_SEED_EN when defined.
// -----------------------------------------------------------------------------
module tb_fib_chk;

    localparam int W      = 4;
    localparam int CW     = 8;
    localparam int MOD    = 16;
    localparam int CNTMAX = 255;
`ifdef FIB_CHK_STRICT_SEED_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          locked;
    logic          err;
    logic          err_sticky;
    logic [W-1:0]  err_exp;
    logic [CW-1:0] term_cnt;

    int testCnt = 0;
    int failCnt = 0;

    // Reference model state
    int hist[$];
    bit mActive;
    bit mLocked;
    bit mErr;
    bit mSticky;
    int mExp;
    int mCnt;

    fib_chk #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .err_exp    (err_exp),
        .term_cnt   (term_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on a difference counts the failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp)
        else begin
            failCnt++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next term the model expects; before two seeds are known this is the
    // canonical seed (only meaningful in the strict build).
    function automatic int expectedTerm();
        if (hist.size() >= 2) begin
            return (hist[hist.size()-2] + hist[hist.size()-1]) % MOD;
        end
        return (hist.size() == 0) ? 0 : 1;
    endfunction

    function automatic void modelReset();
        hist.delete();
        mActive = 1'b0;
        mLocked = 1'b0;
        mErr    = 1'b0;
        mSticky = 1'b0;
        mExp    = 0;
        mCnt    = 0;
    endfunction

    // Effect of one rising edge with the given inputs.
    function automatic void modelEdge(input bit e, input bit v, input bit c, input int d);
        bit xfer;
        bit checked;
        int ex;
        xfer    = e && mActive && v;
        checked = (hist.size() >= 2) || STRICT;
        ex      = expectedTerm();
        mErr    = 1'b0;
        if (c) mSticky = 1'b0;
        if (xfer) begin
            if (checked && (d != ex)) begin
                mErr    = 1'b1;
                mSticky = 1'b1;
                mExp    = ex;
                mCnt    = 0;
                mLocked = 1'b0;
                hist.delete();
                hist.push_back(d);
            end else begin
                if (hist.size() >= 2) begin
                    if (mCnt < CNTMAX) mCnt++;
                    if (mCnt >= 3) mLocked = 1'b1;
                end
                hist.push_back(d);
                if (hist.size() > 2) void'(hist.pop_front());
            end
        end
        if (!e) begin
            mLocked = 1'b0;
            hist.delete();
        end
        mActive = e;
    endfunction

    task automatic checkRegs();
        checkOutput("err",        32'(err),        32'(mErr));
        checkOutput("err_sticky", 32'(err_sticky), 32'(mSticky));
        checkOutput("err_exp",    32'(err_exp),    32'(mExp));
        checkOutput("term_cnt",   32'(term_cnt),   32'(mCnt));
        checkOutput("locked",     32'(locked),     32'(mLocked));
    endtask

    // One clock of stimulus, entered shortly after a rising edge.
    task automatic applyStimulus(input bit e, input bit v, input bit c, input int d);
        en       = e;
        in_valid = v;
        clr      = c;
        in_data  = W'(d);
        #2;
        checkOutput("in_ready", 32'(in_ready), 32'(e && mActive));
        modelEdge(e, v, c, d);
        @(posedge clk);
        #1;
        checkRegs();
    endtask

    task automatic feed(input int d);
        applyStimulus(1'b1, 1'b1, 1'b0, d);
    endtask

    // Drop en for one cycle, then re-enable so the next term is SEED0.
    task automatic restart();
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
    endtask

    // Asynchronous reset pulse in the middle of a clock period.
    task automatic pulseReset(input string tag);
        rst = 1'b0;
        #1;
        checkOutput({tag, ".in_ready"},   32'(in_ready),   32'd0);
        checkOutput({tag, ".locked"},     32'(locked),     32'd0);
        checkOutput({tag, ".err"},        32'(err),        32'd0);
        checkOutput({tag, ".err_sticky"}, 32'(err_sticky), 32'd0);
        checkOutput({tag, ".err_exp"},    32'(err_exp),    32'd0);
        checkOutput({tag, ".term_cnt"},   32'(term_cnt),   32'd0);
        modelReset();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int s034[10];
        int n;
        rst      = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        modelReset();
        @(posedge clk);
        #1;
        pulseReset("reset");

        // Clean sequence with wrap-around; lock after the third checked term.
        s034 = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2};
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            feed(s034[i]);
            if (i == 3) checkOutput("seq.locked_before", 32'(locked), 32'd0);
            if (i == 4) checkOutput("seq.locked_rise",   32'(locked), 32'd1);
        end
        checkOutput("seq.term_cnt",   32'(term_cnt),   32'd8);
        checkOutput("seq.err_sticky", 32'(err_sticky), 32'd0);

        // Wrong term, then resync on the following pair.
        restart();
        feed(0); feed(1); feed(1); feed(2); feed(4);
        checkOutput("miss.err",      32'(err),      32'd1);
        checkOutput("miss.err_exp",  32'(err_exp),  32'd3);
        checkOutput("miss.term_cnt", 32'(term_cnt), 32'd0);
        checkOutput("miss.locked",   32'(locked),   32'd0);
        feed(6); feed(10);
`ifndef FIB_CHK_STRICT_SEED_EN
        checkOutput("resync.err",      32'(err),      32'd0);
        checkOutput("resync.term_cnt", 32'(term_cnt), 32'd1);
`endif

        // Mismatch together with clr keeps the sticky flag; clr alone clears.
        applyStimulus(1'b1, 1'b1, 1'b1, (expectedTerm() + 1) % MOD);
        checkOutput("clr_set.err_sticky", 32'(err_sticky), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 0);
        checkOutput("clr.err_sticky", 32'(err_sticky), 32'd0);

        // en dropped mid-stream: seeds must be relearnt.
        restart();
        feed(0); feed(1); feed(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        checkOutput("en_low.locked", 32'(locked), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        feed(5); feed(8); feed(13);
`ifndef FIB_CHK_STRICT_SEED_EN
        checkOutput("relearn.err",        32'(err),        32'd0);
        checkOutput("relearn.err_sticky", 32'(err_sticky), 32'd0);
`endif

        // Reset at a random phase of a running stream.
        restart();
        feed(0); feed(1);
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) feed(expectedTerm());
        pulseReset("mid_reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        feed(7); feed(3); feed(10);
`ifndef FIB_CHK_STRICT_SEED_EN
        checkOutput("after_reset.err",      32'(err),      32'd0);
        checkOutput("after_reset.term_cnt", 32'(term_cnt), 32'd1);
`endif

        // Counter saturation, then a mismatch still clears it.
        restart();
        feed(0); feed(1);
        for (int i = 0; i < 258; i++) feed(expectedTerm());
        checkOutput("sat.term_cnt", 32'(term_cnt), 32'd255);
        feed((expectedTerm() + 5) % MOD);
        checkOutput("sat_miss.term_cnt", 32'(term_cnt), 32'd0);
        checkOutput("sat_miss.err",      32'(err),      32'd1);

`ifdef FIB_CHK_STRICT_SEED_EN
        // Non-canonical seeds are mismatches against the required seed.
        restart();
        feed(2);
        checkOutput("strict.err",     32'(err),     32'd1);
        checkOutput("strict.err_exp", 32'(err_exp), 32'd0);
        feed(3);
        feed(1);
        checkOutput("strict.seed1_ok", 32'(err), 32'd0);
`endif

        // Randomised traffic with occasional bad terms, stalls, en drops, clr.
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit v;
            bit c;
            int d;
            e = ($urandom_range(0, 99) >= 5);
            v = ($urandom_range(0, 99) < 80);
            c = ($urandom_range(0, 99) < 5);
            d = ($urandom_range(0, 99) < 85) ? expectedTerm() : int'($urandom_range(0, MOD - 1));
            applyStimulus(e, v, c, d);
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule : tb_fib_chk
